// File: rtl/mult_div_unit.sv
// Multicycle multiply/divide unit: shift-add multiply and restoring divide on operand
// magnitudes, one step per cycle, with result signs applied when the last step retires.
//
// state  | meaning
// IDLE   | waiting for start; operands latched when start is seen
// RUN    | one arithmetic step per cycle, WIDTH steps in total
// FINISH | single-cycle done (and div_zero) pulse, hi/lo already updated
module mult_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_RUN    = 2'd1,
    S_FINISH = 2'd2
  } state_t;

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             is_div_q, is_div_d;
  logic [WIDTH:0]   opa_q, opa_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic             neg_lo_q, neg_lo_d;
  logic             neg_hi_q, neg_hi_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic             done_q, done_d;
  logic             div_zero_q, div_zero_d;
  logic             busy_q, busy_d;

  logic             is_signed, a_neg, b_neg;
  logic [WIDTH:0]   a_ext, b_ext, a_mag, b_mag;
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH-1:0] mul_acc, mul_q;
  logic [WIDTH:0]   div_shift, div_diff;
  logic             div_ge;
  logic [WIDTH-1:0] div_acc, div_q;
  logic [WIDTH-1:0] step_acc, step_q;
  logic [2*WIDTH-1:0] prod, prod_fix;
  logic [WIDTH-1:0] quo_fix, rem_fix;

  // Magnitudes are formed from a sign-extended WIDTH+1 value so -2^(WIDTH-1) negates cleanly.
  always_comb begin
    is_signed = ~op[0];
    a_neg     = is_signed & a[WIDTH-1];
    b_neg     = is_signed & b[WIDTH-1];
    a_ext     = {a_neg, a};
    b_ext     = {b_neg, b};
    a_mag     = a_neg ? -a_ext : a_ext;
    b_mag     = b_neg ? -b_ext : b_ext;
  end

  // Datapath step: {acc,q} is the partial product or the remainder:quotient pair.
  always_comb begin
    mul_sum   = {1'b0, acc_q} + (q_q[0] ? opa_q : '0);
    mul_acc   = mul_sum[WIDTH:1];
    mul_q     = {mul_sum[0], q_q[WIDTH-1:1]};

    div_shift = {acc_q, q_q[WIDTH-1]};
    div_diff  = div_shift - opa_q;
    div_ge    = ~div_diff[WIDTH];
    div_acc   = div_ge ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];
    div_q     = {q_q[WIDTH-2:0], div_ge};

    step_acc  = is_div_q ? div_acc : mul_acc;
    step_q    = is_div_q ? div_q : mul_q;

    prod      = {step_acc, step_q};
    prod_fix  = neg_lo_q ? -prod : prod;
    quo_fix   = neg_lo_q ? -step_q : step_q;
    rem_fix   = neg_hi_q ? -step_acc : step_acc;
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    is_div_d   = is_div_q;
    opa_d      = opa_q;
    acc_d      = acc_q;
    q_d        = q_q;
    neg_lo_d   = neg_lo_q;
    neg_hi_d   = neg_hi_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    done_d     = 1'b0;
    div_zero_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          is_div_d = op[1];
          opa_d    = op[1] ? b_mag : a_mag;
          q_d      = op[1] ? a_mag[WIDTH-1:0] : b_mag[WIDTH-1:0];
          acc_d    = '0;
          neg_lo_d = a_neg ^ b_neg;
          neg_hi_d = a_neg;
          cnt_d    = '0;
          if (op[1] && (b == '0)) begin
            state_d    = S_FINISH;
            done_d     = 1'b1;
            div_zero_d = 1'b1;
          end else begin
            state_d = S_RUN;
          end
        end
      end
      S_RUN: begin
        acc_d = step_acc;
        q_d   = step_q;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CNT_LAST) begin
          state_d = S_FINISH;
          done_d  = 1'b1;
          hi_d    = is_div_q ? rem_fix : prod_fix[2*WIDTH-1:WIDTH];
          lo_d    = is_div_q ? quo_fix : prod_fix[WIDTH-1:0];
        end
      end
      S_FINISH: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      is_div_q   <= 1'b0;
      opa_q      <= '0;
      acc_q      <= '0;
      q_q        <= '0;
      neg_lo_q   <= 1'b0;
      neg_hi_q   <= 1'b0;
      hi_q       <= '0;
      lo_q       <= '0;
      done_q     <= 1'b0;
      div_zero_q <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      is_div_q   <= is_div_d;
      opa_q      <= opa_d;
      acc_q      <= acc_d;
      q_q        <= q_d;
      neg_lo_q   <= neg_lo_d;
      neg_hi_q   <= neg_hi_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
      done_q     <= done_d;
      div_zero_q <= div_zero_d;
      busy_q     <= busy_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign div_zero = div_zero_q;
  assign hi       = hi_q;
  assign lo       = lo_q;

endmodule
